// File: rtl/regfile_fwd_v2.sv
// ID-stage GPR + HI/LO register file with youngest-first forwarding and hazard stall.
// Build option: define REGFILE_FWD_EN to enable forwarding. Otherwise any stage match stalls.

module regfile_fwd_rport #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NFWD = 3
) (
    input  logic               en,
    input  logic [AW-1:0]      addr,
    input  logic [DW-1:0]      arr_data,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [DW-1:0]      wdata,
    input  logic [NFWD-1:0]    fwd_we,
    input  logic [NFWD-1:0]    fwd_rdy,
    input  logic [NFWD*AW-1:0] fwd_waddr,
    input  logic [NFWD*DW-1:0] fwd_wdata,
    output logic [DW-1:0]      data,
    output logic               hazard
);

`ifdef REGFILE_FWD_EN
    logic hit;

    // The first (youngest) matching stage wins, even when its data is not ready yet.
    always_comb begin
        data   = '0;
        hazard = 1'b0;
        hit    = 1'b0;
        if (addr != '0) begin
            for (int s = 0; s < NFWD; s++) begin
                if (!hit && fwd_we[s] && fwd_waddr[s*AW +: AW] == addr) begin
                    hit    = 1'b1;
                    data   = fwd_wdata[s*DW +: DW];
                    hazard = en && !fwd_rdy[s];
                end
            end
            if (!hit)
                data = (we && waddr == addr) ? wdata : arr_data;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_rdy, fwd_wdata};

    always_comb begin
        data   = '0;
        hazard = 1'b0;
        if (addr != '0) begin
            data = (we && waddr == addr) ? wdata : arr_data;
            for (int s = 0; s < NFWD; s++)
                if (fwd_we[s] && fwd_waddr[s*AW +: AW] == addr)
                    hazard = en;
        end
    end
`endif

endmodule

module regfile_fwd_hlsel #(
    parameter int DW   = 32,
    parameter int NFWD = 3
) (
    input  logic [NFWD-1:0]    fwd_we,
    input  logic [NFWD*DW-1:0] fwd_data,
    input  logic               we,
    input  logic [DW-1:0]      wdata,
    input  logic [DW-1:0]      q,
    output logic [DW-1:0]      data
);

`ifdef REGFILE_FWD_EN
    logic hit;

    always_comb begin
        data = we ? wdata : q;
        hit  = 1'b0;
        for (int s = 0; s < NFWD; s++) begin
            if (!hit && fwd_we[s]) begin
                hit  = 1'b1;
                data = fwd_data[s*DW +: DW];
            end
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_we, fwd_data};
    assign data = we ? wdata : q;
`endif

endmodule

module regfile_fwd_v2 #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int NREAD = 2,
    parameter int NFWD  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREAD-1:0]   rd_en,
    input  logic [NREAD*AW-1:0] raddr,
    output logic [NREAD*DW-1:0] rdata,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [DW-1:0]      wdata,
    input  logic [NFWD-1:0]    fwd_we,
    input  logic [NFWD-1:0]    fwd_rdy,
    input  logic [NFWD*AW-1:0] fwd_waddr,
    input  logic [NFWD*DW-1:0] fwd_wdata,
    input  logic               hi_we,
    input  logic               lo_we,
    input  logic [DW-1:0]      hi_i,
    input  logic [DW-1:0]      lo_i,
    input  logic [NFWD-1:0]    fwd_hi_we,
    input  logic [NFWD-1:0]    fwd_lo_we,
    input  logic [NFWD*DW-1:0] fwd_hi,
    input  logic [NFWD*DW-1:0] fwd_lo,
    input  logic               hilo_rd,
    input  logic               md_start,
    input  logic               md_done,
    output logic [DW-1:0]      hi_o,
    output logic [DW-1:0]      lo_o,
    output logic               stall_req,
    output logic               hilo_busy,
    output logic [31:0]        stall_cnt
);

    localparam int NREGS = 2**AW;

    logic [DW-1:0]    gpr [NREGS];
    logic [DW-1:0]    hi_q, lo_q;
    logic [NREAD-1:0] port_haz;
    logic             hilo_haz;

    // Entry 0 is reset and never written, so it stays 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                gpr[i] <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (we && waddr != '0)
                gpr[waddr] <= wdata;
            if (hi_we)
                hi_q <= hi_i;
            if (lo_we)
                lo_q <= lo_i;
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_rport
        regfile_fwd_rport #(.DW(DW), .AW(AW), .NFWD(NFWD)) u_rport (
            .en       (rd_en[p]),
            .addr     (raddr[p*AW +: AW]),
            .arr_data (gpr[raddr[p*AW +: AW]]),
            .we       (we),
            .waddr    (waddr),
            .wdata    (wdata),
            .fwd_we   (fwd_we),
            .fwd_rdy  (fwd_rdy),
            .fwd_waddr(fwd_waddr),
            .fwd_wdata(fwd_wdata),
            .data     (rdata[p*DW +: DW]),
            .hazard   (port_haz[p])
        );
    end

    regfile_fwd_hlsel #(.DW(DW), .NFWD(NFWD)) u_hi (
        .fwd_we(fwd_hi_we), .fwd_data(fwd_hi), .we(hi_we), .wdata(hi_i), .q(hi_q), .data(hi_o)
    );

    regfile_fwd_hlsel #(.DW(DW), .NFWD(NFWD)) u_lo (
        .fwd_we(fwd_lo_we), .fwd_data(fwd_lo), .we(lo_we), .wdata(lo_i), .q(lo_q), .data(lo_o)
    );

`ifdef REGFILE_FWD_EN
    assign hilo_haz = 1'b0;
`else
    // Without forwarding, an in-flight HI/LO writer must retire before ID reads.
    assign hilo_haz = hilo_rd && (|fwd_hi_we || |fwd_lo_we);
`endif

    assign stall_req = |port_haz || hilo_haz || (hilo_rd && hilo_busy);

    // A start in the same cycle as a done is a back-to-back op, so start wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            hilo_busy <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (md_start)
                hilo_busy <= 1'b1;
            else if (md_done)
                hilo_busy <= 1'b0;
            if (stall_req && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_regfile_fwd_v2.sv
// Directed + random bench for regfile_fwd_v2 against an array/scan reference model.
module tb_regfile_fwd_v2;
    localparam int DW = 32, AW = 5, NREAD = 2, NFWD = 3;

`ifdef REGFILE_FWD_EN
    localparam bit          FWD      = 1'b1;
    localparam logic [31:0] PRIO_EXP = 32'h3333_3333;
    localparam logic [31:0] R9_EXP   = 32'h0000_0099;
    localparam logic [31:0] R9_STALL = 32'd0;
`else
    localparam bit          FWD      = 1'b0;
    localparam logic [31:0] PRIO_EXP = 32'h1111_1111;
    localparam logic [31:0] R9_EXP   = 32'h0000_0000;
    localparam logic [31:0] R9_STALL = 32'd1;
`endif

    logic clk, rst;
    logic [NREAD-1:0]    rd_en;
    logic [NREAD*AW-1:0] raddr;
    logic [NREAD*DW-1:0] rdata;
    logic                we;
    logic [AW-1:0]       waddr;
    logic [DW-1:0]       wdata;
    logic [NFWD-1:0]     fwd_we, fwd_rdy, fwd_hi_we, fwd_lo_we;
    logic [NFWD*AW-1:0]  fwd_waddr;
    logic [NFWD*DW-1:0]  fwd_wdata, fwd_hi, fwd_lo;
    logic                hi_we, lo_we, hilo_rd, md_start, md_done;
    logic [DW-1:0]       hi_i, lo_i, hi_o, lo_o;
    logic                stall_req, hilo_busy;
    logic [31:0]         stall_cnt;

    regfile_fwd_v2 #(.DW(DW), .AW(AW), .NREAD(NREAD), .NFWD(NFWD)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .raddr(raddr), .rdata(rdata),
        .we(we), .waddr(waddr), .wdata(wdata),
        .fwd_we(fwd_we), .fwd_rdy(fwd_rdy), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
        .hi_we(hi_we), .lo_we(lo_we), .hi_i(hi_i), .lo_i(lo_i),
        .fwd_hi_we(fwd_hi_we), .fwd_lo_we(fwd_lo_we), .fwd_hi(fwd_hi), .fwd_lo(fwd_lo),
        .hilo_rd(hilo_rd), .md_start(md_start), .md_done(md_done),
        .hi_o(hi_o), .lo_o(lo_o), .stall_req(stall_req), .hilo_busy(hilo_busy),
        .stall_cnt(stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int nvec = 0, nerr = 0;

    // Reference state
    logic [DW-1:0] m_gpr [32];
    logic [DW-1:0] m_hi, m_lo;
    bit            m_busy, m_stall;
    logic [31:0]   m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int first_set(input logic [NFWD-1:0] v);
        for (int s = 0; s < NFWD; s++)
            if (v[s]) return s;
        return -1;
    endfunction

    function automatic int stage_match(input logic [AW-1:0] a);
        for (int s = 0; s < NFWD; s++)
            if (fwd_we[s] && fwd_waddr[s*AW +: AW] == a) return s;
        return -1;
    endfunction

    task automatic settle();
        logic [DW-1:0] d, eh, el;
        bit h, any_h;
        int s, sh, sl;
        logic [AW-1:0] a;
        #2;
        any_h = 1'b0;
        for (int p = 0; p < NREAD; p++) begin
            a = raddr[p*AW +: AW];
            d = '0;
            h = 1'b0;
            if (a != 0) begin
                s = stage_match(a);
                if (FWD && s >= 0) begin
                    d = fwd_wdata[s*DW +: DW];
                    h = rd_en[p] && !fwd_rdy[s];
                end else begin
                    d = (we && waddr == a) ? wdata : m_gpr[a];
                    h = !FWD && rd_en[p] && s >= 0;
                end
            end
            any_h |= h;
            if (!(FWD && h)) chk($sformatf("rdata%0d", p), rdata[p*DW +: DW], d);
        end
        sh = first_set(fwd_hi_we);
        sl = first_set(fwd_lo_we);
        eh = (FWD && sh >= 0) ? fwd_hi[sh*DW +: DW] : (hi_we ? hi_i : m_hi);
        el = (FWD && sl >= 0) ? fwd_lo[sl*DW +: DW] : (lo_we ? lo_i : m_lo);
        m_stall = any_h || (hilo_rd && m_busy) ||
                  (!FWD && hilo_rd && (fwd_hi_we != 0 || fwd_lo_we != 0));
        chk("hi_o", hi_o, eh);
        chk("lo_o", lo_o, el);
        chk("stall_req", stall_req, m_stall);
        chk("hilo_busy", hilo_busy, m_busy);
        chk("stall_cnt", stall_cnt, m_cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_gpr[i] = '0;
            m_hi = '0; m_lo = '0; m_busy = 1'b0; m_cnt = '0;
        end else begin
            if (we && waddr != 0) m_gpr[waddr] = wdata;
            if (hi_we) m_hi = hi_i;
            if (lo_we) m_lo = lo_i;
            m_busy = md_start ? 1'b1 : (md_done ? 1'b0 : m_busy);
            if (m_stall && m_cnt != 32'hFFFF_FFFF) m_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic stage(input int s, input bit w, input bit r, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        fwd_we[s] = w; fwd_rdy[s] = r;
        fwd_waddr[s*AW +: AW] = a; fwd_wdata[s*DW +: DW] = d;
    endtask

    task automatic rport(input int p, input bit e, input logic [AW-1:0] a);
        rd_en[p] = e;
        raddr[p*AW +: AW] = a;
    endtask

    logic [31:0] cnt0;

    initial begin
        rst = 1'b1; rd_en = '0; raddr = '0; we = 1'b0; waddr = '0; wdata = '0;
        fwd_we = '0; fwd_rdy = '0; fwd_waddr = '0; fwd_wdata = '0;
        fwd_hi_we = '0; fwd_lo_we = '0; fwd_hi = '0; fwd_lo = '0;
        hi_we = 1'b0; lo_we = 1'b0; hi_i = '0; lo_i = '0;
        hilo_rd = 1'b0; md_start = 1'b0; md_done = 1'b0;
        m_stall = 1'b0;
        tick();
        rst = 1'b0;

        // Reset state
        rport(0, 1'b1, 5'd5);
        settle();
        chk("rst_rdata0", rdata[DW-1:0], 32'h0);
        chk("rst_hi_o", hi_o, 32'h0);
        chk("rst_stall", stall_req, 32'h0);
        chk("rst_cnt", stall_cnt, 32'h0);
        tick();

        // Forwarding priority
        rport(0, 1'b0, 5'd0);
        we = 1'b1; waddr = 5'd3; wdata = 32'h1111_1111;
        step();
        we = 1'b0;
        stage(2, 1'b1, 1'b1, 5'd3, 32'h2222_2222);
        stage(1, 1'b1, 1'b1, 5'd3, 32'h3333_3333);
        rport(1, 1'b1, 5'd3);
        settle();
        chk("prio_rdata1", rdata[2*DW-1:DW], PRIO_EXP);
        tick();
        stage(1, 1'b0, 1'b0, 5'd0, 32'h0);
        stage(2, 1'b0, 1'b0, 5'd0, 32'h0);
        settle();
        chk("prio_array", rdata[2*DW-1:DW], 32'h1111_1111);
        tick();

        // Load-use
        rport(1, 1'b0, 5'd0);
        stage(0, 1'b1, 1'b0, 5'd7, 32'h0);
        stage(1, 1'b1, 1'b1, 5'd7, 32'hAA);
        rport(0, 1'b1, 5'd7);
        settle();
        chk("lu_stall", stall_req, 32'd1);
        cnt0 = m_cnt;
        tick();
        settle();
        chk("lu_cnt_inc", stall_cnt, cnt0 + 32'd1);
        tick();
        rport(0, 1'b0, 5'd7);
        settle();
        chk("lu_noen", stall_req, 32'd0);
        tick();

        // r0 never forwards, never commits
        stage(1, 1'b0, 1'b0, 5'd0, 32'h0);
        stage(0, 1'b1, 1'b0, 5'd0, 32'hFFFF);
        rport(0, 1'b1, 5'd0);
        we = 1'b1; waddr = 5'd0; wdata = 32'h1234;
        settle();
        chk("r0_rdata", rdata[DW-1:0], 32'h0);
        chk("r0_stall", stall_req, 32'd0);
        tick();
        we = 1'b0;
        stage(0, 1'b0, 1'b0, 5'd0, 32'h0);
        settle();
        chk("r0_commit", rdata[DW-1:0], 32'h0);
        tick();

        // HI/LO busy
        rport(0, 1'b0, 5'd0);
        md_start = 1'b1;
        step();
        md_start = 1'b0;
        hilo_rd = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            settle();
            chk("md_stall", stall_req, 32'd1);
            tick();
        end
        md_done = 1'b1; hi_we = 1'b1; hi_i = 32'hDEAD;
        settle();
        chk("md_stall4", stall_req, 32'd1);
        chk("md_hi_wt", hi_o, 32'hDEAD);
        tick();
        md_done = 1'b0; hi_we = 1'b0; hilo_rd = 1'b0;
        settle();
        chk("md_idle", hilo_busy, 32'd0);
        chk("md_hi_reg", hi_o, 32'hDEAD);
        tick();
        md_start = 1'b1;
        step();
        md_done = 1'b1;
        step();
        md_start = 1'b0; md_done = 1'b0;
        settle();
        chk("md_b2b", hilo_busy, 32'd1);
        tick();

        // Reset while busy
        hilo_rd = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        chk("rst_busy", hilo_busy, 32'd0);
        chk("rst_stall2", stall_req, 32'd0);
        chk("rst_cnt2", stall_cnt, 32'd0);
        tick();
        hilo_rd = 1'b0;

        // Build-dependent forwarding
        stage(1, 1'b1, 1'b1, 5'd9, 32'h99);
        rport(0, 1'b1, 5'd9);
        settle();
        chk("r9_stall", stall_req, R9_STALL);
        chk("r9_rdata", rdata[DW-1:0], R9_EXP);
        tick();
        fwd_hi_we = 3'b010; fwd_hi[DW +: DW] = 32'h5555; hilo_rd = 1'b1;
        rport(0, 1'b0, 5'd0);
        step();

        // Random
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(63) == 0);
            for (int p = 0; p < NREAD; p++)
                rport(p, $urandom_range(1), ($urandom_range(3) == 0) ? AW'($urandom) : AW'($urandom_range(3)));
            we = $urandom_range(1); waddr = AW'($urandom_range(3)); wdata = $urandom;
            for (int s = 0; s < NFWD; s++) begin
                stage(s, $urandom_range(1), $urandom_range(3) != 0, AW'($urandom_range(3)), $urandom);
                fwd_hi[s*DW +: DW] = $urandom;
                fwd_lo[s*DW +: DW] = $urandom;
            end
            fwd_hi_we = NFWD'($urandom_range(7) == 0 ? $urandom : 0);
            fwd_lo_we = NFWD'($urandom_range(7) == 0 ? $urandom : 0);
            hi_we = $urandom_range(3) == 0; hi_i = $urandom;
            lo_we = $urandom_range(3) == 0; lo_i = $urandom;
            hilo_rd = $urandom_range(1);
            md_start = $urandom_range(7) == 0;
            md_done = $urandom_range(3) == 0;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
